// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives trial codes into the R2R DAC
// and resolves one bit per step from the synchronized comparator output.
module sar_adc_ctrl #(
  parameter int WIDTH    = 8,
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cont,
  input  logic [SETTLE_W-1:0] settle,
  input  logic                comp_in,
  output logic [WIDTH-1:0]    dac_code,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SYNC0,
    SYNC1,
    DECIDE
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          sync_reg;
  logic                comp_s;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [SETTLE_W-1:0] cnt_reg, cnt_next;
  logic [SETTLE_W-1:0] settle_l_reg, settle_l_next;
  logic [WIDTH-1:0]    dac_reg, dac_next;
  logic [WIDTH-1:0]    result_reg, result_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  assign comp_s   = sync_reg[1];
  assign dac_code = dac_reg;
  assign result   = result_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sync_reg     <= '0;
      idx_reg      <= '0;
      cnt_reg      <= '0;
      settle_l_reg <= '0;
      dac_reg      <= '0;
      result_reg   <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sync_reg     <= {sync_reg[0], comp_in};
      idx_reg      <= idx_next;
      cnt_reg      <= cnt_next;
      settle_l_reg <= settle_l_next;
      dac_reg      <= dac_next;
      result_reg   <= result_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    cnt_next      = cnt_reg;
    settle_l_next = settle_l_reg;
    dac_next      = dac_reg;
    result_next   = result_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start || cont) begin
          settle_l_next       = settle;
          cnt_next            = settle;
          idx_next            = IDX_W'(WIDTH - 1);
          dac_next            = '0;
          dac_next[WIDTH-1]   = 1'b1;
          busy_next           = 1'b1;
          state_next          = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_reg == '0) state_next = SYNC0;
        else               cnt_next   = cnt_reg - SETTLE_W'(1);
      end
      // Two wait states cover the comparator synchronizer latency.
      SYNC0:   state_next = SYNC1;
      SYNC1:   state_next = DECIDE;
      DECIDE: begin
        if (!comp_s) dac_next[idx_reg] = 1'b0;
        if (idx_reg != '0) begin
          idx_next                         = idx_reg - IDX_W'(1);
          dac_next[idx_reg - IDX_W'(1)]    = 1'b1;
          cnt_next                         = settle_l_reg;
          state_next                       = SETTLE;
        end else begin
          result_next = dac_next;
          done_next   = 1'b1;
          busy_next   = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: comparator model on the DAC code, and a
// scoreboard of expected results and done edges checked when done pulses.
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic [7:0] settle;
  logic       comp_in;
  logic [7:0] dac_code;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] vin;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [7:0] res;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  logic [7:0] prev_result = 8'h00;

  sar_adc_ctrl #(.WIDTH(8), .SETTLE_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cont    (cont),
    .settle  (settle),
    .comp_in (comp_in),
    .dac_code(dac_code),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  assign comp_in = (vin >= dac_code);

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  // Scoreboard monitor, sampled 1 time unit after each active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      sb.delete();
      prev_result = result;
    end else begin
      if (!done && result !== prev_result) check("result_hold", result, prev_result);
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", done, 1'b0);
        end else begin
          e = sb.pop_front();
          $display("done edge=%0d result=0x%02h expected=0x%02h busy=%0b",
                   edge_cnt, result, e.res, busy);
          check("done_edge", edge_cnt, e.cyc);
          check("result", result, e.res);
          check("dac_final", dac_code, e.res);
          check("busy_at_done", busy, 1'b0);
        end
      end
      prev_result = result;
    end
  end

  task automatic start_conv(input logic [7:0] v, input logic [7:0] s, output int s_edge);
    exp_t e;
    @(negedge clk);
    vin    = v;
    settle = s;
    start  = 1'b1;
    s_edge = edge_cnt + 1;
    e.res  = v;
    e.cyc  = s_edge + 8 * (int'(s) + 4);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_edge(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("pending_done", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_edge;
    logic [7:0] trials [8];
    logic [7:0] vals [3];
    trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    vals   = '{8'h00, 8'hFF, 8'h80};

    rst = 1'b1; start = 1'b0; cont = 1'b0; settle = 8'd0; vin = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_dac", dac_code, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    rst = 1'b0;

    // Basic conversion with trial sequence check.
    start_conv(8'hA5, 8'd3, s_edge);
    for (int b = 0; b < 8; b++) begin
      wait_edge(s_edge + b * 7);
      check("trial_code", dac_code, trials[b]);
      if (b == 0) check("busy_during", busy, 1'b1);
    end
    wait_idle(100);

    // Extremes and midscale at zero settle.
    for (int i = 0; i < 3; i++) begin
      start_conv(vals[i], 8'd0, s_edge);
      wait_idle(60);
    end

    // Start re-pulsed while busy is ignored.
    start_conv(8'h3C, 8'd0, s_edge);
    wait_edge(s_edge + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_edge(s_edge + 19);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(60);
    repeat (10) @(negedge clk);
    check("no_restart_busy", busy, 1'b0);

    // Reset mid-conversion aborts without done.
    start_conv(8'h77, 8'd0, s_edge);
    wait_edge(s_edge + 16);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_dac", dac_code, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_result", result, 8'h00);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    start_conv(8'h5A, 8'd0, s_edge);
    wait_idle(60);

    // Continuous mode, back-to-back conversions.
    begin
      exp_t e;
      @(negedge clk);
      vin    = 8'h10;
      settle = 8'd1;
      cont   = 1'b1;
      s_edge = edge_cnt + 1;
      e.res = 8'h10; e.cyc = s_edge + 40; sb.push_back(e);
      e.res = 8'hE7; e.cyc = s_edge + 81; sb.push_back(e);
      wait_edge(s_edge + 40);
      vin = 8'hE7;
      wait_edge(s_edge + 45);
      cont = 1'b0;
      wait_idle(150);
    end

    // Settle change mid-conversion has no effect; next start re-latches.
    start_conv(8'hC3, 8'd2, s_edge);
    wait_edge(s_edge + 10);
    settle = 8'd9;
    wait_idle(100);
    start_conv(8'h4E, 8'd9, s_edge);
    wait_idle(200);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Successive-approximation ADC controller. It reuses the 8-bit R2R DAC as the reference ladder and one external analog comparator to digitise an analog input into a code. This is the read-back counterpart to the sine sample generator: the DAC generator writes codes out, and this block recovers codes from an analog level. It sits between the comparator pad and the on-chip logic. The SAR trial code drives the DAC mux while a conversion is in progress.

Parameters:
WIDTH, 8, number of result bits and DAC code width
SETTLE_W, 8, width of the settle-time input

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
start  input  1  level-sampled request; starts a conversion when sampled high in IDLE
cont  input  1  continuous mode; when high, the next conversion starts automatically after done
settle  input  SETTLE_W  DAC settle wait in clocks per bit; latched at conversion start
comp_in  input  1  asynchronous comparator output; 1 = Vin >= Vdac
dac_code  output  WIDTH  trial code to the R2R DAC
busy  output  1  high from the first SETTLE cycle through the final DECIDE cycle
done  output  1  one-cycle pulse when result is updated
result  output  WIDTH  last completed conversion value

Behaviour:
- comp_in passes through a 2-flop synchronizer (comp_s). The synchronizer is clocked always and is cleared to 0 by rst.
- State register, bit index idx (log2 WIDTH bits), settle counter cnt (SETTLE_W bits), latched settle_l.
- Reset values: state=IDLE, dac_code=0, result=0, busy=0, done=0, idx=0, cnt=0.
- done defaults to 0 every cycle. It is set only on the final DECIDE edge.
- IDLE:
  - If start=1 or cont=1: settle_l<=settle, cnt<=settle, idx<=WIDTH-1, dac_code<={1'b1,0...}, busy<=1, go to SETTLE.
  - Otherwise dac_code holds its last value.
- SETTLE: if cnt==0, go to SYNC0; else cnt<=cnt-1. The state lasts settle_l+1 cycles.
- SYNC0 -> SYNC1 -> DECIDE, one cycle each. These cover synchronizer latency.
- DECIDE:
  - If comp_s==0, clear dac_code[idx]; otherwise keep it.
  - If idx!=0: idx<=idx-1, set dac_code[idx-1], cnt<=settle_l, go to SETTLE.
  - If idx==0: result<=final code (with the bit-0 decision applied), done<=1, busy<=0, go to IDLE.
  - dac_code holds the final code after completion.
- Timing per bit: settle_l+4 cycles.
  - Start sampled at edge 0 gives done high in the cycle after edge WIDTH*(settle_l+4).
  - With settle=0 and WIDTH=8, done is high after edge 32.
- Continuous mode: on a done cycle the FSM is in IDLE. With cont=1 the next conversion starts at the following edge, so there is exactly one IDLE cycle between conversions. settle is re-latched at each start.
- Boundary rules:
  - start while busy is ignored and not queued.
  - settle changes mid-conversion have no effect.
  - rst mid-conversion forces all reset values on the next edge and aborts with no done.
  - result changes only on a done edge.
- Width rules: dac_code and result are WIDTH bits. cnt is unsigned and never underflows.

Test Plan:
All scenarios use a comparator model comp_in = (vin >= dac_code), evaluated combinationally on the bench.

- vin=0xA5, settle=3, start pulse -> done after 8*7=56 edges, result=0xA5, busy low at done. The dac_code trial sequence is 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
- vin=0x00 -> result=0x00; vin=0xFF -> result=0xFF; vin=0x80 -> result=0x80. All use settle=0, with done exactly 32 edges after start.
- start re-pulsed at cycles 5 and 20 of a conversion, vin=0x3C -> a single done, result=0x3C, no restart.
- rst asserted at cycle 17 of a conversion -> next cycle dac_code=0, busy=0, result=0, done never pulses. A new start then converts vin=0x5A to 0x5A.
- cont=1, settle=1, vin stepping 0x10 then 0xE7 between conversions -> back-to-back done pulses 41 cycles apart, with results 0x10 then 0xE7.
- settle changed from 2 to 9 mid-conversion -> that conversion keeps the 6-cycle-per-bit spacing. The next conversion uses 13 cycles per bit.
